// File: rtl/posit_mul_arbiter_pkg.sv
// Shared posit types and arbiter definitions: operand/product containers,
// default sizing, arbiter state encoding and the in-flight tag record.
package posit_mul_arbiter_pkg;

    typedef logic [15:0] value;
    typedef logic [31:0] value_product;

    localparam int NREQ_DEF    = 4;
    localparam int MUL_LAT_DEF = 4;
    // Wide enough for the largest supported requester count (8).
    localparam int ID_W        = 3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        HALT  = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
    } tag_t;

endpackage

// File: rtl/posit_mul_arbiter_if.sv
// Bundle of request, multiplier and result signals shared by the arbiter
// (slave side) and whatever drives it (master side).
interface posit_mul_arbiter_if import posit_mul_arbiter_pkg::*; #(
    parameter int NREQ = NREQ_DEF
) ();
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    value [NREQ-1:0] req_a;
    value [NREQ-1:0] req_b;
    logic            mul_valid_o;
    value            mul_a;
    value            mul_b;
    logic            mul_valid_i;
    value_product    mul_result;
    logic [NREQ-1:0] res_valid;
    value_product    res_data;
    logic            flush;
    logic            idle;
    logic            err;

    modport slave (
        input  req_valid, req_a, req_b, mul_valid_i, mul_result, flush,
        output req_ready, mul_valid_o, mul_a, mul_b, res_valid, res_data, idle, err
    );

    modport master (
        output req_valid, req_a, req_b, mul_valid_i, mul_result, flush,
        input  req_ready, mul_valid_o, mul_a, mul_b, res_valid, res_data, idle, err
    );
endinterface

// File: rtl/posit_mul_arbiter_rr_arbiter.sv
// Combinational round-robin pick: the first valid requester found searching
// circularly from rr_ptr+1, reported both one-hot and as an index.
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0]         req_valid,
    input  logic [$clog2(NREQ)-1:0] rr_ptr,
    output logic [NREQ-1:0]         grant,
    output logic [$clog2(NREQ)-1:0] grant_idx,
    output logic                    grant_any
);
    localparam int PTR_W = $clog2(NREQ);

    int               cand;
    logic [PTR_W-1:0] cand_idx;

    always_comb begin
        grant     = '0;
        grant_idx = rr_ptr;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(rr_ptr) + k) % NREQ;
            cand_idx = PTR_W'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
        grant[grant_idx] = grant_any;
    end
endmodule

// File: rtl/posit_mul_arbiter.sv
// Round-robin share of one fixed-latency posit multiplier among NREQ requesters,
// with tag-based result routing and flush/drain. POSIT_ARB_PERF_EN adds perf counters.
module posit_mul_arbiter import posit_mul_arbiter_pkg::*; #(
    parameter int NREQ    = NREQ_DEF,
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    posit_mul_arbiter_if.slave  bus
`ifdef POSIT_ARB_PERF_EN
    ,
    output logic [31:0]         perf_grants,
    output logic [31:0]         perf_stalls
`endif
);
    localparam int PTR_W = $clog2(NREQ);

    arb_state_e       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] grant_idx;
    logic [NREQ-1:0]  grant;
    logic [NREQ-1:0]  ready;
    logic             grant_any;
    logic             accept;

    logic             mul_valid_q;
    value             mul_a_q;
    value             mul_b_q;
    logic [ID_W-1:0]  issue_id;

    tag_t             pipe [MUL_LAT];
    tag_t             last;
    logic             pipe_busy;

    logic [NREQ-1:0]  res_valid_q;
    value_product     res_data_q;
    logic             err_q;

    rr_arbiter #(.NREQ(NREQ)) u_rr (
        .req_valid (bus.req_valid),
        .rr_ptr    (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    // A same-cycle flush wins over the grant; nothing is offered while in reset.
    assign ready  = (rst_n && state == RUN && !bus.flush) ? grant : '0;
    assign accept = grant_any && (ready != '0);
    assign last   = pipe[MUL_LAT-1];

    always_comb begin
        pipe_busy = 1'b0;
        for (int k = 0; k < MUL_LAT; k++) begin
            pipe_busy = pipe_busy | pipe[k].valid;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= RUN;
            rr_ptr <= PTR_W'(NREQ - 1);
        end else begin
            if (accept) begin
                rr_ptr <= grant_idx;
            end
            case (state)
                RUN:     if (bus.flush) state <= DRAIN;
                DRAIN:   if (!pipe_busy && !mul_valid_q) state <= HALT;
                HALT:    if (!bus.flush) state <= RUN;
                default: state <= RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            issue_id    <= '0;
        end else begin
            mul_valid_q <= accept;
            if (accept) begin
                mul_a_q  <= bus.req_a[grant_idx];
                mul_b_q  <= bus.req_b[grant_idx];
                issue_id <= ID_W'(grant_idx);
            end
        end
    end

    // Tag stages mirror the multiplier's latency so the last stage lines up with mul_valid_i.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < MUL_LAT; k++) begin
                pipe[k] <= '0;
            end
        end else begin
            pipe[0] <= '{valid: mul_valid_q, id: issue_id};
            for (int k = 1; k < MUL_LAT; k++) begin
                pipe[k] <= pipe[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= '0;
            res_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            res_valid_q <= '0;
            if (bus.mul_valid_i && last.valid) begin
                res_valid_q <= NREQ'(1) << last.id;
                res_data_q  <= bus.mul_result;
            end
            if (bus.mul_valid_i != last.valid) begin
                err_q <= 1'b1;
            end
        end
    end

`ifdef POSIT_ARB_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_grants <= '0;
            perf_stalls <= '0;
        end else begin
            if (accept && perf_grants != '1) begin
                perf_grants <= perf_grants + 32'd1;
            end
            if ((bus.req_valid != '0) && !accept && perf_stalls != '1) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

    assign bus.req_ready   = ready;
    assign bus.mul_valid_o = mul_valid_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.err         = err_q;
    assign bus.idle        = (state == HALT) ||
                             (!pipe_busy && !mul_valid_q && res_valid_q == '0 && bus.req_valid == '0);
endmodule

// File: tb/tb_posit_mul_arbiter.sv
// Directed bench for posit_mul_arbiter (NREQ=4, MUL_LAT=4) with a delay-line multiplier model.
module tb_posit_mul_arbiter;
    import posit_mul_arbiter_pkg::*;

    logic clk;
    logic rst_n;
    logic inject;
    int   checks;
    int   passes;

    posit_mul_arbiter_if #(.NREQ(4)) bus ();

`ifdef POSIT_ARB_PERF_EN
    logic [31:0] perf_grants;
    logic [31:0] perf_stalls;
`endif

    posit_mul_arbiter #(.NREQ(4), .MUL_LAT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef POSIT_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External multiplier: a 4-deep delay line returning the plain integer product.
    logic         mv [4];
    value_product md [4];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                mv[k] <= 1'b0;
                md[k] <= '0;
            end
        end else begin
            mv[0] <= bus.mul_valid_o;
            md[0] <= {16'h0000, bus.mul_a} * {16'h0000, bus.mul_b};
            for (int k = 1; k < 4; k++) begin
                mv[k] <= mv[k-1];
                md[k] <= md[k-1];
            end
        end
    end

    assign bus.mul_valid_i = mv[3] | inject;
    assign bus.mul_result  = md[3];

    // Requester i always offers a = 0x0100+i, b = 0x0002+i.
    function automatic value_product prod(input int i);
        return value_product'((256 + i) * (2 + i));
    endfunction

    function automatic logic [3:0] onehot(input int i);
        logic [3:0] v;
        v = 4'b0001;
        return v << i;
    endfunction

    task automatic test_reset();
        rst_n     = 1'b0;
        inject    = 1'b0;
        bus.flush = 1'b0;
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            bus.req_a[i] = value'(256 + i);
            bus.req_b[i] = value'(2 + i);
        end
        repeat (2) @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL reset_ready: got %b want 0000", bus.req_ready); else passes++;
        checks++; if (bus.mul_valid_o !== 1'b0) $display("[TB] FAIL reset_mul_valid: got %b want 0", bus.mul_valid_o); else passes++;
        checks++; if (bus.mul_a !== 16'h0 || bus.mul_b !== 16'h0) $display("[TB] FAIL reset_mul_ab: got %h/%h want 0/0", bus.mul_a, bus.mul_b); else passes++;
        checks++; if (bus.res_valid !== 4'b0000) $display("[TB] FAIL reset_res_valid: got %b want 0000", bus.res_valid); else passes++;
        checks++; if (bus.res_data !== 32'h0) $display("[TB] FAIL reset_res_data: got %h want 0", bus.res_data); else passes++;
        checks++; if (bus.err !== 1'b0) $display("[TB] FAIL reset_err: got %b want 0", bus.err); else passes++;
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.idle !== 1'b1) $display("[TB] FAIL reset_idle: got %b want 1", bus.idle); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fairness();
        int rcount;
        rcount = 0;
        bus.req_valid = 4'b1111;
        for (int cyc = 0; cyc < 30 && rcount < 8; cyc++) begin
            if (cyc == 8) bus.req_valid = 4'b0000;
            #1;
            if (cyc < 8) begin
                checks++; if (bus.req_ready !== onehot(cyc % 4)) $display("[TB] FAIL fair_grant[%0d]: got %b want %b", cyc, bus.req_ready, onehot(cyc % 4)); else passes++;
            end
            if (cyc >= 1 && cyc <= 8) begin
                checks++; if (bus.mul_valid_o !== 1'b1 || bus.mul_a !== value'(256 + (cyc - 1) % 4))
                    $display("[TB] FAIL fair_issue[%0d]: got v=%b a=%h want v=1 a=%h", cyc, bus.mul_valid_o, bus.mul_a, 256 + (cyc - 1) % 4); else passes++;
            end
            if (bus.res_valid !== 4'b0000) begin
                checks++; if (bus.res_valid !== onehot(rcount % 4) || bus.res_data !== prod(rcount % 4))
                    $display("[TB] FAIL fair_result[%0d]: got %b/%h want %b/%h", rcount, bus.res_valid, bus.res_data, onehot(rcount % 4), prod(rcount % 4)); else passes++;
                rcount++;
            end
            @(negedge clk);
        end
        checks++; if (rcount !== 8) $display("[TB] FAIL fair_count: got %0d results want 8", rcount); else passes++;
    endtask

    task automatic test_mixed_valid();
        int rcount;
        int id;
        rcount = 0;
        bus.req_valid = 4'b1010;
        for (int cyc = 0; cyc < 30 && rcount < 4; cyc++) begin
            if (cyc == 4) bus.req_valid = 4'b0000;
            #1;
            if (cyc < 4) begin
                id = (cyc % 2 == 0) ? 1 : 3;
                checks++; if (bus.req_ready !== onehot(id)) $display("[TB] FAIL mixed_grant[%0d]: got %b want %b", cyc, bus.req_ready, onehot(id)); else passes++;
            end
            if (bus.res_valid !== 4'b0000) begin
                id = (rcount % 2 == 0) ? 1 : 3;
                checks++; if (bus.res_valid !== onehot(id) || bus.res_data !== prod(id))
                    $display("[TB] FAIL mixed_result[%0d]: got %b/%h want %b/%h", rcount, bus.res_valid, bus.res_data, onehot(id), prod(id)); else passes++;
                rcount++;
            end
            @(negedge clk);
        end
        checks++; if (rcount !== 4) $display("[TB] FAIL mixed_count: got %0d results want 4", rcount); else passes++;
    endtask

    task automatic test_single();
        int n;
        bus.req_valid = 4'b0001;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) $display("[TB] FAIL single_ready: got %b want 0001", bus.req_ready); else passes++;
        @(negedge clk);
        bus.req_valid = 4'b0000;
        #1;
        checks++; if (bus.mul_valid_o !== 1'b1 || bus.mul_a !== 16'h0100 || bus.mul_b !== 16'h0002)
            $display("[TB] FAIL single_issue: got v=%b a=%h b=%h want 1/0100/0002", bus.mul_valid_o, bus.mul_a, bus.mul_b); else passes++;
        n = 1;
        while (n < 20 && bus.res_valid === 4'b0000) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++; if (n !== 6) $display("[TB] FAIL single_latency: got %0d cycles want 6", n); else passes++;
        checks++; if (bus.res_valid !== 4'b0001 || bus.res_data !== 32'h0000_0200)
            $display("[TB] FAIL single_result: got %b/%h want 0001/00000200", bus.res_valid, bus.res_data); else passes++;
        @(negedge clk);
        #1;
        checks++; if (bus.res_valid !== 4'b0000) $display("[TB] FAIL single_pulse: got %b want 0000", bus.res_valid); else passes++;
        checks++; if (bus.idle !== 1'b1) $display("[TB] FAIL single_idle: got %b want 1", bus.idle); else passes++;
        @(negedge clk);
    endtask

    task automatic test_flush();
        logic [3:0] exp_g [3];
        int pulses;
        logic done;
        exp_g[0] = 4'b0010;
        exp_g[1] = 4'b0100;
        exp_g[2] = 4'b0001;
        bus.req_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (bus.req_ready !== exp_g[k]) $display("[TB] FAIL flush_issue[%0d]: got %b want %b", k, bus.req_ready, exp_g[k]); else passes++;
            @(negedge clk);
        end
        bus.req_valid = 4'b1111;
        bus.flush = 1'b1;
        pulses = 0;
        done = 1'b0;
        #1;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL flush_ready[%0d]: got %b want 0000", cyc, bus.req_ready); else passes++;
            if (bus.res_valid !== 4'b0000) pulses++;
            if (bus.idle === 1'b1) begin
                done = 1'b1;
            end else begin
                @(negedge clk);
                #1;
            end
        end
        checks++; if (done !== 1'b1) $display("[TB] FAIL flush_halt: got idle=%b want 1", bus.idle); else passes++;
        checks++; if (pulses !== 3) $display("[TB] FAIL flush_pulses: got %0d want 3", pulses); else passes++;
        bus.flush = 1'b0;
        #1;
        checks++; if (bus.req_ready !== 4'b0000) $display("[TB] FAIL flush_halt_ready: got %b want 0000", bus.req_ready); else passes++;
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) $display("[TB] FAIL flush_resume: got %b want 0010", bus.req_ready); else passes++;
        bus.req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_protocol_error();
        bus.req_valid = 4'b0000;
        inject = 1'b1;
        #1;
        checks++; if (bus.err !== 1'b0) $display("[TB] FAIL err_before: got %b want 0", bus.err); else passes++;
        @(negedge clk);
        inject = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.err !== 1'b1 || bus.res_valid !== 4'b0000)
                $display("[TB] FAIL err_sticky[%0d]: got err=%b res=%b want 1/0000", k, bus.err, bus.res_valid); else passes++;
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        checks++; if (bus.err !== 1'b0) $display("[TB] FAIL err_clear: got %b want 0", bus.err); else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_midflight();
        bus.req_valid = 4'b0011;
        #1;
        checks++; if (bus.req_ready !== 4'b0001) $display("[TB] FAIL midrst_grant0: got %b want 0001", bus.req_ready); else passes++;
        @(negedge clk);
        #1;
        checks++; if (bus.req_ready !== 4'b0010) $display("[TB] FAIL midrst_grant1: got %b want 0010", bus.req_ready); else passes++;
        @(negedge clk);
        bus.req_valid = 4'b0000;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (bus.mul_valid_o !== 1'b0 || bus.mul_a !== 16'h0 || bus.mul_b !== 16'h0)
            $display("[TB] FAIL midrst_mul: got %b/%h/%h want 0/0/0", bus.mul_valid_o, bus.mul_a, bus.mul_b); else passes++;
        checks++; if (bus.res_valid !== 4'b0000 || bus.res_data !== 32'h0)
            $display("[TB] FAIL midrst_res: got %b/%h want 0000/0", bus.res_valid, bus.res_data); else passes++;
        checks++; if (bus.idle !== 1'b1 || bus.err !== 1'b0 || bus.req_ready !== 4'b0000)
            $display("[TB] FAIL midrst_status: got idle=%b err=%b ready=%b want 1/0/0000", bus.idle, bus.err, bus.req_ready); else passes++;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            checks++; if (bus.res_valid !== 4'b0000 || bus.err !== 1'b0)
                $display("[TB] FAIL midrst_stale[%0d]: got res=%b err=%b want 0000/0", k, bus.res_valid, bus.err); else passes++;
        end
    endtask

    initial begin
        checks = 0;
        passes = 0;
        test_reset();
        test_fairness();
        test_mixed_valid();
        test_single();
        test_flush();
        test_protocol_error();
        test_reset_midflight();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
